// File: rtl/spi_pkg.sv
// spi_pkg: shared widths, field sizes and enums for the SPI slave.
//   DWIDTH     - maximum data field width
//   AWIDTH     - register address width
//   CTRL_NBITS - WRITE(1) + SIZE(2) + ADDR(AWIDTH)
//   WAIT_NBITS - sample edges between control field and read data
package spi_pkg;

  localparam int unsigned DWIDTH     = 32;
  localparam int unsigned AWIDTH     = 12;
  localparam int unsigned CTRL_NBITS = AWIDTH + 3;
  localparam int unsigned WAIT_NBITS = 2;
  // Wide enough to hold DWIDTH itself.
  localparam int unsigned CNT_W      = 6;

  typedef enum logic [1:0] {
    SZ8     = 2'd0,
    SZ16    = 2'd1,
    SZ32    = 2'd2,
    SZ_RSVD = 2'd3
  } size_e;

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StRxCtrl = 3'd1,
    StRxData = 3'd2,
    StWait   = 3'd3,
    StTxData = 3'd4,
    StAccess = 3'd5
  } state_e;

  // Data field length in bits for a legal size code.
  function automatic logic [CNT_W-1:0] size_nbits(input size_e sz);
    unique case (sz)
      SZ8:     return CNT_W'(8);
      SZ16:    return CNT_W'(16);
      default: return CNT_W'(32);
    endcase
  endfunction

endpackage

// File: rtl/spi_slave_sync.sv
// spi_slave_sync: synchronises sck, ss_n and mosi into clk and derives
// single-clk edge pulses.
//   clk, rst_n       - system clock, async active-low reset
//   i_sck/i_ss_n/i_mosi - raw SPI pins
//   i_cfg_mode       - {CPOL,CPHA}; selects which sck edge is the sample edge
//   o_sample_pulse   - one clk per sample edge
//   o_change_pulse   - one clk per change edge
//   o_ss_fall/o_ss_rise - one clk per synchronised ss_n edge
//   o_mosi_s         - synchronised mosi, aligned with the sck pipeline
// SYNC_STAGES must be >= 2.
module spi_slave_sync #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_sck,
  input  logic       i_ss_n,
  input  logic       i_mosi,
  input  logic [1:0] i_cfg_mode,
  output logic       o_sample_pulse,
  output logic       o_change_pulse,
  output logic       o_ss_fall,
  output logic       o_ss_rise,
  output logic       o_mosi_s
);

  logic [SYNC_STAGES-1:0] r_sck_sync;
  logic [SYNC_STAGES-1:0] r_ss_sync;
  logic [SYNC_STAGES-1:0] r_mosi_sync;
  logic                   r_sck_prev;
  logic                   r_ss_prev;

  logic w_sck_s;
  logic w_ss_s;
  logic w_sck_rise;
  logic w_sck_fall;
  logic w_rise_samples;

  // ss_n resets to deasserted so leaving reset never looks like a frame start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sck_sync  <= '0;
      r_ss_sync   <= '1;
      r_mosi_sync <= '0;
      r_sck_prev  <= 1'b0;
      r_ss_prev   <= 1'b1;
    end else begin
      r_sck_sync  <= {r_sck_sync[SYNC_STAGES-2:0], i_sck};
      r_ss_sync   <= {r_ss_sync[SYNC_STAGES-2:0], i_ss_n};
      r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], i_mosi};
      r_sck_prev  <= r_sck_sync[SYNC_STAGES-1];
      r_ss_prev   <= r_ss_sync[SYNC_STAGES-1];
    end
  end

  assign w_sck_s    = r_sck_sync[SYNC_STAGES-1];
  assign w_ss_s     = r_ss_sync[SYNC_STAGES-1];
  assign w_sck_rise = w_sck_s & ~r_sck_prev;
  assign w_sck_fall = ~w_sck_s & r_sck_prev;

  // Modes 0 and 3 sample on the rising edge, modes 1 and 2 on the falling edge.
  assign w_rise_samples = ~(i_cfg_mode[1] ^ i_cfg_mode[0]);

  assign o_sample_pulse = w_rise_samples ? w_sck_rise : w_sck_fall;
  assign o_change_pulse = w_rise_samples ? w_sck_fall : w_sck_rise;
  assign o_ss_fall      = ~w_ss_s & r_ss_prev;
  assign o_ss_rise      = w_ss_s & ~r_ss_prev;
  assign o_mosi_s       = r_mosi_sync[SYNC_STAGES-1];

endmodule

// File: rtl/spi_slave.sv
// spi_slave: SPI peripheral that decodes WRITE|SIZE|ADDR|DATA frames (MSB first)
// into single-cycle register-bank accesses.
//   clk, rst_n          - system clock, async active-low reset
//   i_cfg_mode          - {CPOL,CPHA}, static while ss_n is low
//   i_sck/i_ss_n/i_mosi - SPI inputs (oversampled)
//   o_miso, o_miso_oe   - read data and its tri-state enable
//   o_reg_addr/o_reg_size - held from end of control field
//   o_reg_wdata         - write data, left-justified, zero-filled
//   o_reg_we/o_reg_re   - one-clk access strobes
//   i_reg_rdata         - read data, valid one clk after o_reg_re
//   o_busy              - frame in progress
//   o_frame_err         - one-clk pulse on abort or reserved size
// Optional: define SPI_SLAVE_STATS_EN to add saturating o_frame_cnt and
// o_abort_cnt counters.
module spi_slave
  import spi_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [1:0]        i_cfg_mode,
  input  logic              i_sck,
  input  logic              i_ss_n,
  input  logic              i_mosi,
  output logic              o_miso,
  output logic              o_miso_oe,
  output logic [AWIDTH-1:0] o_reg_addr,
  output logic [DWIDTH-1:0] o_reg_wdata,
  output logic [1:0]        o_reg_size,
  output logic              o_reg_we,
  output logic              o_reg_re,
  input  logic [DWIDTH-1:0] i_reg_rdata,
  output logic              o_busy,
`ifdef SPI_SLAVE_STATS_EN
  output logic [15:0]       o_frame_cnt,
  output logic [15:0]       o_abort_cnt,
`endif
  output logic              o_frame_err
);

  logic w_sample;
  logic w_change;
  logic w_ss_fall;
  logic w_ss_rise;
  logic w_mosi_s;

  spi_slave_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk           (clk),
    .rst_n         (rst_n),
    .i_sck         (i_sck),
    .i_ss_n        (i_ss_n),
    .i_mosi        (i_mosi),
    .i_cfg_mode    (i_cfg_mode),
    .o_sample_pulse(w_sample),
    .o_change_pulse(w_change),
    .o_ss_fall     (w_ss_fall),
    .o_ss_rise     (w_ss_rise),
    .o_mosi_s      (w_mosi_s)
  );

  state_e                r_state, w_state_nxt;
  logic [CNT_W-1:0]      r_cnt, w_cnt_nxt;
  // Control and data shifters omit the top bit; it lives only in the *_full wires.
  logic [CTRL_NBITS-2:0] r_ctrl, w_ctrl_nxt;
  logic [DWIDTH-2:0]     r_data, w_data_nxt;
  logic [DWIDTH-1:0]     r_tx, w_tx_nxt;
  logic [AWIDTH-1:0]     r_addr, w_addr_nxt;
  size_e                 r_size, w_size_nxt;
  logic [DWIDTH-1:0]     r_wdata, w_wdata_nxt;
  logic                  r_we, w_we_nxt;
  logic                  r_re, w_re_nxt;
  logic                  r_err, w_err_nxt;
  logic                  r_oe, w_oe_nxt;
  logic                  r_cap, w_cap_nxt;
  logic                  r_chg_seen, w_chg_seen_nxt;

  logic [CTRL_NBITS-1:0] w_ctrl_full;
  logic [DWIDTH-1:0]     w_data_full;
  logic [CNT_W-1:0]      w_nbits;
  logic                  w_abort;
  size_e                 w_rx_size;

  assign w_ctrl_full = {r_ctrl, w_mosi_s};
  assign w_data_full = {r_data, w_mosi_s};
  assign w_nbits     = size_nbits(r_size);
  assign w_rx_size   = size_e'(w_ctrl_full[AWIDTH+1:AWIDTH]);
  // ss_n rising mid-frame aborts; ACCESS has already committed the write.
  assign w_abort     = w_ss_rise && (r_state != StIdle) && (r_state != StAccess);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= StIdle;
      r_cnt      <= '0;
      r_ctrl     <= '0;
      r_data     <= '0;
      r_tx       <= '0;
      r_addr     <= '0;
      r_size     <= SZ8;
      r_wdata    <= '0;
      r_we       <= 1'b0;
      r_re       <= 1'b0;
      r_err      <= 1'b0;
      r_oe       <= 1'b0;
      r_cap      <= 1'b0;
      r_chg_seen <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_ctrl     <= w_ctrl_nxt;
      r_data     <= w_data_nxt;
      r_tx       <= w_tx_nxt;
      r_addr     <= w_addr_nxt;
      r_size     <= w_size_nxt;
      r_wdata    <= w_wdata_nxt;
      r_we       <= w_we_nxt;
      r_re       <= w_re_nxt;
      r_err      <= w_err_nxt;
      r_oe       <= w_oe_nxt;
      r_cap      <= w_cap_nxt;
      r_chg_seen <= w_chg_seen_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_cnt_nxt      = r_cnt;
    w_ctrl_nxt     = r_ctrl;
    w_data_nxt     = r_data;
    w_tx_nxt       = r_tx;
    w_addr_nxt     = r_addr;
    w_size_nxt     = r_size;
    w_wdata_nxt    = r_wdata;
    w_we_nxt       = 1'b0;
    w_re_nxt       = 1'b0;
    w_err_nxt      = 1'b0;
    w_oe_nxt       = r_oe;
    w_chg_seen_nxt = r_chg_seen;
    // Bank returns data the clk after the read strobe; grab it one clk later.
    w_cap_nxt      = r_re;
    if (r_cap) begin
      w_tx_nxt = i_reg_rdata;
    end

    if (w_abort) begin
      w_state_nxt = StIdle;
      w_cnt_nxt   = '0;
      w_err_nxt   = 1'b1;
      w_oe_nxt    = 1'b0;
    end else begin
      unique case (r_state)
        StIdle: begin
          // Only a fresh ss_n fall starts a frame; stray sck edges are ignored.
          if (w_ss_fall) begin
            w_state_nxt = StRxCtrl;
            w_cnt_nxt   = '0;
            w_ctrl_nxt  = '0;
            w_data_nxt  = '0;
          end
        end
        StRxCtrl: begin
          if (w_sample) begin
            w_ctrl_nxt = w_ctrl_full[CTRL_NBITS-2:0];
            w_cnt_nxt  = r_cnt + CNT_W'(1);
            if (r_cnt == CNT_W'(CTRL_NBITS - 1)) begin
              w_cnt_nxt = '0;
              if (w_rx_size == SZ_RSVD) begin
                w_err_nxt   = 1'b1;
                w_state_nxt = StIdle;
              end else begin
                w_addr_nxt = w_ctrl_full[AWIDTH-1:0];
                w_size_nxt = w_rx_size;
                if (w_ctrl_full[CTRL_NBITS-1]) begin
                  w_state_nxt = StRxData;
                end else begin
                  w_state_nxt = StWait;
                  w_re_nxt    = 1'b1;
                end
              end
            end
          end
        end
        StRxData: begin
          if (w_sample) begin
            w_data_nxt = w_data_full[DWIDTH-2:0];
            w_cnt_nxt  = r_cnt + CNT_W'(1);
            if (r_cnt == w_nbits - CNT_W'(1)) begin
              w_cnt_nxt   = '0;
              w_state_nxt = StAccess;
              w_we_nxt    = 1'b1;
              // Left-justify; older bits shift out the top.
              w_wdata_nxt = w_data_full << (CNT_W'(DWIDTH) - w_nbits);
            end
          end
        end
        StWait: begin
          if (w_sample) begin
            w_cnt_nxt = r_cnt + CNT_W'(1);
            if (r_cnt == CNT_W'(WAIT_NBITS - 1)) begin
              w_cnt_nxt      = '0;
              w_state_nxt    = StTxData;
              w_oe_nxt       = 1'b1;
              w_chg_seen_nxt = 1'b0;
            end
          end
        end
        StTxData: begin
          // The first change edge keeps the MSB on the line for the first sample.
          if (w_change) begin
            if (r_chg_seen) begin
              w_tx_nxt = {r_tx[DWIDTH-2:0], 1'b0};
            end
            w_chg_seen_nxt = 1'b1;
          end
          if (w_sample) begin
            w_cnt_nxt = r_cnt + CNT_W'(1);
            if (r_cnt == w_nbits - CNT_W'(1)) begin
              w_cnt_nxt   = '0;
              w_state_nxt = StIdle;
              w_oe_nxt    = 1'b0;
            end
          end
        end
        StAccess: begin
          w_state_nxt = StIdle;
        end
        default: begin
          w_state_nxt = StIdle;
        end
      endcase
    end
  end

  assign o_miso      = r_oe & r_tx[DWIDTH-1];
  assign o_miso_oe   = r_oe;
  assign o_reg_addr  = r_addr;
  assign o_reg_wdata = r_wdata;
  assign o_reg_size  = r_size;
  assign o_reg_we    = r_we;
  assign o_reg_re    = r_re;
  assign o_busy      = (r_state != StIdle);
  assign o_frame_err = r_err;

`ifdef SPI_SLAVE_STATS_EN
  logic [15:0] r_frame_cnt;
  logic [15:0] r_abort_cnt;
  logic        w_rd_done;

  assign w_rd_done = (r_state == StTxData) && (w_state_nxt == StIdle) && !w_err_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_frame_cnt <= '0;
      r_abort_cnt <= '0;
    end else begin
      if ((r_we || w_rd_done) && (r_frame_cnt != 16'hFFFF)) begin
        r_frame_cnt <= r_frame_cnt + 16'd1;
      end
      if (r_err && (r_abort_cnt != 16'hFFFF)) begin
        r_abort_cnt <= r_abort_cnt + 16'd1;
      end
    end
  end

  assign o_frame_cnt = r_frame_cnt;
  assign o_abort_cnt = r_abort_cnt;
`endif

endmodule

// File: doc/spi_slave.md
Name: spi_slave

Overview:
- Peripheral end of the team's 4-slave SPI link: decodes frames from the SPI master and turns them into single-cycle register-bank accesses.
- Frame format, MSB first: WRITE(1) | SIZE(2) | ADDR(AWIDTH) | DATA, where DATA is 8, 16 or 32 bits.
- Read frames: after the control field, the master waits 2 sck periods, then the slave returns read data on miso.
- One instance sits behind each ss_n line; it is fully synchronous to clk and oversamples sck, ss_n and mosi.

Parameters:
- DWIDTH, 32, maximum data field width; taken from spi_pkg.
- AWIDTH, 12, register address width; taken from spi_pkg.
- SYNC_STAGES, 2, synchroniser depth on sck, ss_n and mosi; must be >= 2.

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset, asynchronous, active-low
- cfg_mode  in  2  {CPOL,CPHA}; static while ss_n is low
- sck  in  1  SPI clock from master
- ss_n  in  1  slave select, active-low
- mosi  in  1  master-out data
- miso  out  1  slave-out data; valid only while miso_oe=1
- miso_oe  out  1  tri-state enable for miso
- reg_addr  out  AWIDTH  register address
- reg_wdata  out  DWIDTH  write data, left-justified, zero-filled below the size
- reg_size  out  2  size code (0=8b, 1=16b, 2=32b)
- reg_we  out  1  one-clk write strobe
- reg_re  out  1  one-clk read strobe
- reg_rdata  in  DWIDTH  read data; valid exactly 1 clk after reg_re
- busy  out  1  high while a frame is in progress
- frame_err  out  1  one-clk pulse when a frame is aborted or illegal

Behaviour:
- Reset values: all outputs 0; miso_oe=0; FSM in IDLE; shift registers and counters cleared.
- Synchronisation and edge detection:
  - sck, ss_n and mosi pass through SYNC_STAGES flops.
  - sck edges are detected in clk using the last two synchronised sck samples.
  - Sample edge is rising when CPOL==CPHA, falling otherwise; change edge is the opposite edge.
  - Required timing: sck half-period >= SYNC_STAGES+2 clk. The master's sck is clk/8, so this holds.
- FSM states: IDLE, RX_CTRL, RX_DATA, WAIT, TX_DATA, ACCESS.
  - IDLE -> RX_CTRL on synchronised ss_n falling; busy=1 from then on.
  - RX_CTRL: shift in AWIDTH+3 bits on sample edges.
    - When the count reaches AWIDTH+3 with SIZE=3: frame_err pulse, go to IDLE and ignore the rest of the frame until ss_n rises.
    - WRITE=1 -> RX_DATA.
    - WRITE=0 -> WAIT, and assert reg_re for one clk on the same cycle. Capture reg_rdata on the next clk into the TX shift register.
  - RX_DATA: shift in nbits = 8 << SIZE on sample edges. On the last bit -> ACCESS: reg_we=1 for one clk, reg_wdata = received bits placed in [DWIDTH-1 -: nbits], remaining bits 0.
  - WAIT: count 2 sample edges, then -> TX_DATA with miso_oe=1.
  - TX_DATA:
    - miso carries the TX shift register MSB, starting with reg_rdata[DWIDTH-1].
    - Shift on each change edge after the first TX-state change edge.
    - After nbits sample edges -> IDLE with miso_oe=0.
  - ACCESS -> IDLE after one clk.
- reg_addr and reg_size are held from end of RX_CTRL until the next frame starts.
- ss_n rises while in any state other than IDLE/ACCESS:
  - Abort: frame_err pulse, no reg_we, miso_oe=0, go to IDLE.
  - A reg_re already issued is not retracted.
- ss_n still low after a frame completes: extra sck edges are ignored. A new frame requires ss_n high then low again.
- sck edges while ss_n is high are ignored.
- rst_n assertion mid-frame: immediate return to reset values. No strobe is emitted.

Optional Feature:
- Macro: SPI_SLAVE_STATS_EN.
- When defined, adds outputs frame_cnt[15:0] and abort_cnt[15:0].
  - frame_cnt increments on each completed read or write frame.
  - abort_cnt increments on each frame_err.
  - Both counters saturate at 16'hFFFF and reset to 0.
- When undefined, these ports and counters do not exist; all other behaviour is identical.

Decomposition:
- spi_pkg holds:
  - DWIDTH and AWIDTH.
  - CTRL_NBITS = AWIDTH+3 and WAIT_NBITS = 2.
  - A size enum (SZ8, SZ16, SZ32, SZ_RSVD).
  - The slave FSM state enum.
- Sub-module spi_slave_sync: synchroniser plus edge detector. Inputs clk, rst_n, sck, ss_n, mosi, cfg_mode; outputs sample_pulse, change_pulse, ss_fall, ss_rise, mosi_s.

Test Plan:
- Mode 00, write: WRITE=1, SIZE=0, ADDR=0x0A5, data 0xC3 -> one reg_we, reg_addr=0x0A5, reg_wdata=0xC3000000, reg_size=0; frame_err=0.
- Mode 11, write: SIZE=2, ADDR=0xFFF, data 0xDEADBEEF -> one reg_we, reg_wdata=0xDEADBEEF.
- Mode 00, read: SIZE=1, ADDR=0x010, reg_rdata=0x1234ABCD -> reg_re at end of control; miso_oe after 2 wait periods; master receives 0x1234; miso_oe=0 after 16 bits.
- Abort: ss_n rises after 5 data bits of a SIZE=0 write -> frame_err pulse, no reg_we, busy=0.
- Illegal: SIZE=3 frame -> frame_err after 15 control bits, no strobe; the next legal write frame completes normally.
- With SPI_SLAVE_STATS_EN defined: 3 good frames and 1 abort -> frame_cnt=3, abort_cnt=1; rst_n pulse clears both counters.
